md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide unit of the 5-stage pipelined MIPS core. Sits beside the ALU in the E stage and owns the HI/LO registers.
- Executes mult/multu/div/divu over a fixed multi-cycle latency, and mthi/mtlo in a single cycle.
- Its busy flag is the source of the md-stall that control raises against md-class instructions in D.
- Feeds HI/LO read data back into the E-stage result mux for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy duration in cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse from E stage when an md-class instruction is in E and not flushed.
- md_op  input  3  operation code: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110/111 reserved.
- A  input  32  forwarded rs value (dividend / multiplicand / mthi-mtlo source).
- B  input  32  forwarded rt value (divisor / multiplier).
- busy  output  1  high while a mult/div is in flight.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.

Behaviour:
- Reset: at an edge with reset=1, hi=0, lo=0, busy=0, counter=0 and state=IDLE. Reset overrides start.
- Reset mid-operation: aborts the operation and discards the pending result.
- States:
  - IDLE: busy=0.
  - RUN: busy=1; the 4-bit counter is loaded with the latency.
- IDLE, start=1, md_op in {000..011}:
  - Compute the result combinationally from A/B and latch it into the internal pend_hi/pend_lo at that edge.
  - Load counter with MULT_CYCLES or DIV_CYCLES and go to RUN.
  - busy rises in the cycle after start.
- RUN:
  - Counter decrements each edge.
  - On the edge where counter==1, commit pend_hi/pend_lo to hi/lo, clear busy and return to IDLE.
  - busy is therefore high for exactly N consecutive cycles. New hi/lo values are visible in the first cycle busy is low.
- mthi/mtlo, IDLE, start=1, md_op=100/101: hi (or lo) <= A at that edge. busy stays 0 and the other register is unchanged.
- start while in RUN: ignored entirely, with no restart and no HI/LO write. Control guarantees this does not happen; the bench checks that it is ignored.
- Reserved md_op with start=1: ignored; state unchanged.
- Arithmetic:
  - mult: signed 32x32 -> 64-bit product; hi = product[63:32], lo = product[31:0].
  - multu: same as mult, unsigned.
  - div: signed; lo = quotient truncated toward zero; hi = remainder, carrying the sign of the dividend.
  - divu: unsigned; lo = quotient, hi = remainder.
- Division edge cases:
  - Divide by zero (B=0, div or divu): the full DIV_CYCLES busy period still runs; hi/lo retain their pre-operation values at commit.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
- hi/lo are register outputs only; there is no combinational path from A/B/start to hi/lo/busy.
- Control consumes busy: stall_md = (start | busy) & D-stage-is-md-class.

Test Plan:
- Reset dominance: reset=1 together with start=1, md_op=000 -> next cycle hi=0, lo=0, busy=0.
- Signed mult: start, md_op=000, A=0xFFFFFFFE (-2), B=0x00000003 -> busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- Unsigned mult: start, md_op=001, A=0xFFFFFFFF, B=0x00000002 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE. hi/lo hold their old values throughout busy.
- Signed div: start, md_op=010, A=0xFFFFFFF9 (-7), B=0x00000002 -> busy for 10 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also check div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero and overlap: preload hi=0x11111111 and lo=0x22222222 via mthi/mtlo (each updates next edge with busy=0). Then divu with B=0 -> busy 10 cycles; hi/lo unchanged. Pulse start with md_op=000 during busy -> ignored, busy still falls on schedule.
- Reset mid-operation: start div, assert reset on the 4th busy cycle -> next cycle busy=0, hi=lo=0. After reset deasserts, a subsequent mtlo A=0x5 gives lo=0x00000005.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: multiply/divide unit of the pipelined MIPS core, owning HI/LO.
// mult/multu/div/divu compute their result in the start cycle, park it in
// pend_hi/pend_lo and commit after a fixed busy period. mthi/mtlo write
// HI/LO directly in a single cycle.
//
// Ports:
//   clk    - system clock, all state updates on the rising edge
//   reset  - synchronous active-high reset (aborts any operation in flight)
//   start  - one-cycle pulse: md-class instruction in E
//   md_op  - 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo
//   A, B   - forwarded rs / rt operands
//   busy   - high while a mult/div is in flight
//   hi, lo - architectural HI / LO registers
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

  logic [0:0]  state_reg;
  logic [3:0]  count_reg;
  logic [31:0] hi_reg, lo_reg;
  logic [31:0] pend_hi_reg, pend_lo_reg;

  // Combinational result datapath
  logic [63:0] prod_s, prod_u;
  logic [31:0] div_b;
  logic [31:0] abs_a, abs_b;
  logic [31:0] mag_q, mag_r;
  logic [31:0] sq, sr, uq, ur;
  logic [31:0] res_hi, res_lo;
  logic        div_zero;

  // Sign-extending to 64 bits first makes the low 64 bits of the unsigned
  // product equal to the two's-complement signed product.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  assign div_zero = (B == 32'd0);
  // Substitute divisor keeps the dividers free of X when B is zero; the
  // result is discarded in that case anyway.
  assign div_b = div_zero ? 32'd1 : B;

  // Signed division done on magnitudes so 0x80000000 / -1 needs no special
  // case: |A| = 0x80000000 unsigned, quotient sign positive -> 0x80000000.
  assign abs_a = A[31] ? (~A + 32'd1) : A;
  assign abs_b = div_b[31] ? (~div_b + 32'd1) : div_b;
  assign mag_q = abs_a / abs_b;
  assign mag_r = abs_a % abs_b;
  assign sq    = (A[31] ^ div_b[31]) ? (~mag_q + 32'd1) : mag_q;
  assign sr    = A[31] ? (~mag_r + 32'd1) : mag_r;
  assign uq    = A / div_b;
  assign ur    = A % div_b;

  always_comb begin
    res_hi = hi_reg;
    res_lo = lo_reg;
    case (md_op)
      3'b000: begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      3'b001: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      // Divide by zero leaves HI/LO as they were before the operation.
      3'b010: if (!div_zero) begin res_hi = sr; res_lo = sq; end
      3'b011: if (!div_zero) begin res_hi = ur; res_lo = uq; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      count_reg   <= 4'd0;
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
      pend_hi_reg <= 32'd0;
      pend_lo_reg <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (!md_op[2]) begin
              pend_hi_reg <= res_hi;
              pend_lo_reg <= res_lo;
              count_reg   <= md_op[1] ? DIV_LAT : MULT_LAT;
              state_reg   <= RUN;
            end else if (md_op == 3'b100) begin
              hi_reg <= A;
            end else if (md_op == 3'b101) begin
              lo_reg <= A;
            end
          end
        end
        RUN: begin
          // start is deliberately not looked at here.
          if (count_reg == 4'd1) begin
            hi_reg    <= pend_hi_reg;
            lo_reg    <= pend_lo_reg;
            count_reg <= 4'd0;
            state_reg <= IDLE;
          end else begin
            count_reg <= count_reg - 4'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          count_reg <= 4'd0;
        end
      endcase
    end
  end

  assign busy = (state_reg == RUN);
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed, self-checking bench for md_unit. Expected HI/LO and
// busy length are pushed to a scoreboard when an operation starts and popped
// when busy falls.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] cur_hi, cur_lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t sb[$];

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a mult/div, follow it to completion and compare against the
  // scoreboard. inject_at > 0 pulses a stray start (mult) on that busy cycle.
  task automatic run_md(input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int cyc, input int inject_at);
    exp_t e;
    int   n;
    sb.push_back('{hi: exp_hi, lo: exp_lo, cycles: cyc});
    start = 1'b1; md_op = op; A = a; B = b;
    tick();
    start = 1'b0; A = 32'h0; B = 32'h0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (n == 1 || n == inject_at) begin
        check({name, " hold_hi"}, hi, cur_hi);
        check({name, " hold_lo"}, lo, cur_lo);
      end
      if (n == inject_at) begin
        start = 1'b1; md_op = 3'b000; A = 32'h0000_0005; B = 32'h0000_0007;
      end
      tick();
      start = 1'b0; A = 32'h0; B = 32'h0;
    end
    e = sb.pop_front();
    check({name, " busy_cycles"}, 32'(n), 32'(e.cycles));
    check({name, " hi"}, hi, e.hi);
    check({name, " lo"}, lo, e.lo);
    cur_hi = e.hi;
    cur_lo = e.lo;
    $display("txn %s op=%b a=%h b=%h busy=%0d hi=%h lo=%h", name, op, a, b, n, hi, lo);
  endtask

  task automatic move_to(input string name, input logic [2:0] op, input logic [31:0] a);
    start = 1'b1; md_op = op; A = a; B = 32'h0;
    tick();
    start = 1'b0; A = 32'h0;
    if (op == 3'b100) cur_hi = a;
    else if (op == 3'b101) cur_lo = a;
    check({name, " busy"}, {31'd0, busy}, 32'd0);
    check({name, " hi"}, hi, cur_hi);
    check({name, " lo"}, lo, cur_lo);
    $display("txn %s op=%b a=%h hi=%h lo=%h", name, op, a, hi, lo);
  endtask

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; md_op = 3'b000; A = 32'h0; B = 32'h0;
    cur_hi = 32'h0; cur_lo = 32'h0;

    // Reset dominance over a simultaneous mult start
    reset = 1'b1; start = 1'b1; md_op = 3'b000; A = 32'h1234_5678; B = 32'h9;
    tick();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    reset = 1'b0; start = 1'b0;
    tick();
    check("post_reset busy", {31'd0, busy}, 32'd0);
    $display("txn reset_dominance busy=%b hi=%h lo=%h", busy, hi, lo);

    run_md("mult",  3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 0);
    run_md("multu", 3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 5, 4);
    run_md("div",   3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 0);
    run_md("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10, 0);
    run_md("divu",  3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 10, 0);

    move_to("mthi", 3'b100, 32'h1111_1111);
    move_to("mtlo", 3'b101, 32'h2222_2222);
    run_md("divu_zero", 3'b011, 32'hDEAD_BEEF, 32'h0, 32'h1111_1111, 32'h2222_2222, 10, 3);

    // Reserved opcode: nothing changes
    start = 1'b1; md_op = 3'b110; A = 32'hAAAA_AAAA; B = 32'h3;
    tick();
    start = 1'b0;
    check("reserved busy", {31'd0, busy}, 32'd0);
    check("reserved hi", hi, cur_hi);
    check("reserved lo", lo, cur_lo);
    $display("txn reserved op=110 busy=%b hi=%h lo=%h", busy, hi, lo);

    // Reset on the 4th busy cycle of a div
    start = 1'b1; md_op = 3'b010; A = 32'd100; B = 32'd7;
    tick();
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 3) begin
      n++;
      tick();
    end
    check("midreset busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset hi", hi, 32'h0);
    check("midreset lo", lo, 32'h0);
    for (int i = 0; i < 12; i++) tick();
    check("midreset discard busy", {31'd0, busy}, 32'd0);
    check("midreset discard hi", hi, 32'h0);
    check("midreset discard lo", lo, 32'h0);
    cur_hi = 32'h0; cur_lo = 32'h0;
    $display("txn reset_mid_div busy=%b hi=%h lo=%h", busy, hi, lo);

    move_to("mtlo_after_reset", 3'b101, 32'h0000_0005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
